// File: rtl/aes_key_schedule_seq.sv
// Sequential FIPS-197 key expansion for AES-128/192/256. Emits one schedule
// word per clock, fills a round-key store, and serves 128-bit round keys from a registered read port.

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y_o = SBOX[a_i];
endmodule

module aes_key_schedule_seq #(
    parameter int MAX_NK = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [32*MAX_NK-1:0]  key_in,
    output logic                  busy,
    output logic                  done,
    output logic                  key_ready,
    output logic                  err,
    output logic                  rk_valid,
    output logic [31:0]           rk_word,
    output logic [5:0]            rk_index,
    input  logic [3:0]            rd_round,
    output logic [127:0]          rd_key
);
    localparam int DEPTH = 4 * (MAX_NK + 7);

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_e;

    state_e            state_q, state_d;
    logic [5:0]        idx_q, idx_d;
    logic [2:0]        ph_q, ph_d;
    logic [3:0]        nk_q, nk_d;
    logic [3:0]        nr_q, nr_d;
    logic [7:0]        rcon_q, rcon_d;
    logic [7:0][31:0]  win_q, win_d;
    logic [31:0]       rk_word_q, rk_word_d;
    logic [5:0]        rk_index_q, rk_index_d;
    logic              rk_valid_q, rk_valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              key_ready_q, key_ready_d;
    logic [127:0]      rd_key_q;
    logic [31:0]       store_q [DEPTH];

    logic              wr_en;
    logic [5:0]        wr_addr;
    logic [31:0]       wr_data;

    logic [0:MAX_NK-1][31:0] key_w;
    logic [3:0]        nk_in;
    logic              legal;
    logic [5:0]        last_idx;
    logic [2:0]        old_sel, load_sel;
    logic [31:0]       prev_w, old_w, rot_w, sb_in, sb_out, temp_w, new_w;
    logic [5:0]        ra;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign key_w = key_in;

    always_comb begin
        case (key_len)
            2'd0:    nk_in = 4'd4;
            2'd1:    nk_in = 4'd6;
            default: nk_in = 4'd8;
        endcase
    end

    assign legal    = (key_len != 2'd3) && (int'(nk_in) <= MAX_NK);
    assign last_idx = 6'({nk_q, 2'b00}) + 6'd28;

    // Window keeps w[i-1] at slot 7 and w[i-Nk] at slot 8-Nk.
    assign old_sel  = 3'(4'd8 - nk_q);
    assign load_sel = 3'(4'd8 - nk_q + idx_q[3:0]);
    assign prev_w   = win_q[7];
    assign old_w    = win_q[old_sel];
    assign rot_w    = {prev_w[23:0], prev_w[31:24]};
    assign sb_in    = (ph_q == 3'd0) ? rot_w : prev_w;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .a_i (sb_in[8*b +: 8]),
            .y_o (sb_out[8*b +: 8])
        );
    end

    always_comb begin
        temp_w = prev_w;
        if (ph_q == 3'd0)
            temp_w = sb_out ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && ph_q == 3'd4)
            temp_w = sb_out;
    end

    assign new_w = old_w ^ temp_w;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ph_d        = ph_q;
        nk_d        = nk_q;
        nr_d        = nr_q;
        rcon_d      = rcon_q;
        win_d       = win_q;
        rk_word_d   = rk_word_q;
        rk_index_d  = rk_index_q;
        rk_valid_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        key_ready_d = key_ready_q;
        wr_en       = 1'b0;
        wr_addr     = idx_q;
        wr_data     = new_w;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (legal) begin
                        state_d     = LOAD;
                        nk_d        = nk_in;
                        nr_d        = nk_in + 4'd6;
                        rcon_d      = 8'h01;
                        ph_d        = 3'd0;
                        idx_d       = 6'd1;
                        for (int j = 0; j < 8; j++) begin
                            win_d[j] = '0;
                            for (int k = 0; k < MAX_NK; k++)
                                if (k + 8 - int'(nk_in) == j) win_d[j] = key_w[k];
                        end
                        rk_word_d   = key_w[0];
                        rk_index_d  = 6'd0;
                        rk_valid_d  = 1'b1;
                        key_ready_d = 1'b0;
                        wr_en       = 1'b1;
                        wr_addr     = 6'd0;
                        wr_data     = key_w[0];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                rk_word_d  = win_q[load_sel];
                rk_index_d = idx_q;
                rk_valid_d = 1'b1;
                wr_en      = 1'b1;
                wr_data    = win_q[load_sel];
                idx_d      = idx_q + 6'd1;
                if (idx_q == 6'(nk_q) - 6'd1) state_d = EXPAND;
            end
            EXPAND: begin
                if (idx_q == last_idx) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    key_ready_d = 1'b1;
                end else begin
                    rk_word_d  = new_w;
                    rk_index_d = idx_q;
                    rk_valid_d = 1'b1;
                    wr_en      = 1'b1;
                    idx_d      = idx_q + 6'd1;
                    win_d      = {new_w, win_q[7:1]};
                    ph_d       = (ph_q == 3'(nk_q - 4'd1)) ? 3'd0 : ph_q + 3'd1;
                    if (ph_q == 3'd0) rcon_d = xtime(rcon_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            ph_q        <= '0;
            nk_q        <= 4'd4;
            nr_q        <= 4'd10;
            rk_word_q   <= '0;
            rk_index_q  <= '0;
            rk_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            key_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ph_q        <= ph_d;
            nk_q        <= nk_d;
            nr_q        <= nr_d;
            rk_word_q   <= rk_word_d;
            rk_index_q  <= rk_index_d;
            rk_valid_q  <= rk_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            key_ready_q <= key_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        rcon_q <= rcon_d;
        win_q  <= win_d;
        if (wr_en) store_q[wr_addr] <= wr_data;
    end

    // Round keys only become visible once the whole schedule is in the store.
    assign ra = {rd_round, 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n)
            rd_key_q <= '0;
        else if (key_ready_q && rd_round <= nr_q)
            rd_key_q <= {store_q[ra], store_q[{rd_round, 2'b01}],
                         store_q[{rd_round, 2'b10}], store_q[{rd_round, 2'b11}]};
        else
            rd_key_q <= '0;
    end

    assign busy      = (state_q == LOAD) || (state_q == EXPAND);
    assign done      = done_q;
    assign key_ready = key_ready_q;
    assign err       = err_q;
    assign rk_valid  = rk_valid_q;
    assign rk_word   = rk_word_q;
    assign rk_index  = rk_index_q;
    assign rd_key    = rd_key_q;
endmodule
